// File: rtl/pid_pkg.sv
// Shared types and arithmetic helpers for the PID term sequencer.
package pid_pkg;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 18;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ERR   = 3'd1,
        MUL_P = 3'd2,
        MUL_I = 3'd3,
        MUL_D = 3'd4
    } state_e;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_W-1:0] v);
        return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > 18'sd32767) begin
            return 16'sh7fff;
        end else if (v < -18'sd32768) begin
            return 16'sh8000;
        end
        return v[DATA_W-1:0];
    endfunction

    function automatic logic signed [ACC_W-1:0] clamp(input logic signed [ACC_W-1:0] v,
                                                      input logic signed [ACC_W-1:0] lim);
        if (v > lim) begin
            return lim;
        end else if (v < -lim) begin
            return -lim;
        end
        return v;
    endfunction

endpackage

// File: rtl/pid_term_sequencer_mul.sv
// Shared 16x16 multiplier; only the low 16 bits are kept, so signedness does not matter.
module pid_term_sequencer_mul
    import pid_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/pid_term_sequencer.sv
// One PID update per start: error/integral/derivative, then three multiplies through one
// multiplier into a saturating accumulator.
module pid_term_sequencer
    import pid_pkg::*;
#(
    parameter int INT_MAX = 16383,
    parameter int OUT_MAX = 32767
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        clear,
    input  logic [15:0] setpoint,
    input  logic [15:0] feedback,
    input  logic [15:0] kp,
    input  logic [15:0] ki,
    input  logic [15:0] kd,
    output logic        busy,
    output logic        done,
    output logic [15:0] u_out
);

    localparam logic signed [ACC_W-1:0] INT_LIM = ACC_W'(INT_MAX);
    localparam logic signed [ACC_W-1:0] OUT_LIM = ACC_W'(OUT_MAX);

    state_e state_q, state_d;
    logic signed [DATA_W-1:0] sp_q, sp_d, fb_q, fb_d;
    logic signed [DATA_W-1:0] kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
    logic signed [DATA_W-1:0] e_q, e_d, integ_q, integ_d, dterm_q, dterm_d;
    logic signed [DATA_W-1:0] e_prev_q, e_prev_d, u_q, u_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     done_q, done_d;

    logic [DATA_W-1:0]        mul_a, mul_b, prod;
    logic signed [DATA_W-1:0] e_new;
    logic signed [ACC_W-1:0]  integ_new, out_new;

    pid_term_sequencer_mul u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (prod)
    );

    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        fb_d      = fb_q;
        kp_d      = kp_q;
        ki_d      = ki_q;
        kd_d      = kd_q;
        e_d       = e_q;
        integ_d   = integ_q;
        dterm_d   = dterm_q;
        e_prev_d  = e_prev_q;
        u_d       = u_q;
        acc_d     = acc_q;
        done_d    = 1'b0;
        mul_a     = '0;
        mul_b     = '0;
        e_new     = sat16(sext(sp_q) - sext(fb_q));
        integ_new = clamp(sext(integ_q) + sext(e_new), INT_LIM);
        out_new   = clamp(acc_q + sext(prod), OUT_LIM);

        // Operand mux follows the state register so the product is ready within each MUL state.
        case (state_q)
            MUL_P: begin mul_a = kp_q; mul_b = e_q;     end
            MUL_I: begin mul_a = ki_q; mul_b = integ_q; end
            MUL_D: begin mul_a = kd_q; mul_b = dterm_q; end
            default: ;
        endcase

        case (state_q)
            IDLE: begin
                if (clear) begin
                    integ_d  = '0;
                    e_prev_d = '0;
                end else if (start) begin
                    sp_d    = setpoint;
                    fb_d    = feedback;
                    kp_d    = kp;
                    ki_d    = ki;
                    kd_d    = kd;
                    state_d = ERR;
                end
            end
            ERR: begin
                e_d     = e_new;
                integ_d = integ_new[DATA_W-1:0];
                dterm_d = sat16(sext(e_new) - sext(e_prev_q));
                state_d = MUL_P;
            end
            MUL_P: begin
                acc_d   = sext(prod);
                state_d = MUL_I;
            end
            MUL_I: begin
                acc_d   = acc_q + sext(prod);
                state_d = MUL_D;
            end
            MUL_D: begin
                u_d      = out_new[DATA_W-1:0];
                e_prev_d = e_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sp_q     <= '0;
            fb_q     <= '0;
            kp_q     <= '0;
            ki_q     <= '0;
            kd_q     <= '0;
            e_q      <= '0;
            integ_q  <= '0;
            dterm_q  <= '0;
            e_prev_q <= '0;
            u_q      <= '0;
            acc_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sp_q     <= sp_d;
            fb_q     <= fb_d;
            kp_q     <= kp_d;
            ki_q     <= ki_d;
            kd_q     <= kd_d;
            e_q      <= e_d;
            integ_q  <= integ_d;
            dterm_q  <= dterm_d;
            e_prev_q <= e_prev_d;
            u_q      <= u_d;
            acc_q    <= acc_d;
            done_q   <= done_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign u_out = u_q;

endmodule

// File: tb/tb_pid_term_sequencer.sv
// Scoreboard bench for pid_term_sequencer: a behavioural PID model pushes expected outputs.
module tb_pid_term_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, clear;
    logic [15:0] setpoint, feedback, kp, ki, kd;
    logic        busy, done;
    logic [15:0] u_out;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];
    int m_integ = 0;
    int m_eprev = 0;

    always #5 clk = ~clk;

    pid_term_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .clear    (clear),
        .setpoint (setpoint),
        .feedback (feedback),
        .kp       (kp),
        .ki       (ki),
        .kd       (kd),
        .busy     (busy),
        .done     (done),
        .u_out    (u_out)
    );

    function automatic int lim(input int v, input int lo, input int hi);
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

    function automatic int wrap16(input int v);
        logic [15:0] l;
        l = v[15:0];
        return int'($signed(l));
    endfunction

    function automatic int model_update(input int sp, input int fb, input int gp, input int gi, input int gd);
        int e, d, u;
        e       = lim(sp - fb, -32768, 32767);
        m_integ = lim(m_integ + e, -16383, 16383);
        d       = lim(e - m_eprev, -32768, 32767);
        u       = wrap16(gp * e) + wrap16(gi * m_integ) + wrap16(gd * d);
        m_eprev = e;
        return lim(u, -32767, 32767);
    endfunction

    function automatic int u_val();
        return int'($signed(u_out));
    endfunction

    task automatic model_reset();
        m_integ = 0;
        m_eprev = 0;
        exp_q.delete();
    endtask

    task automatic drive(input int sp, input int fb, input int gp, input int gi, input int gd);
        setpoint = 16'(sp);
        feedback = 16'(fb);
        kp       = 16'(gp);
        ki       = 16'(gi);
        kd       = 16'(gd);
    endtask

    // Present an update request at a negedge and record what the model expects from it.
    task automatic apply(input int sp, input int fb, input int gp, input int gi, input int gd);
        drive(sp, fb, gp, gi, gd);
        start = 1'b1;
        exp_q.push_back(model_update(sp, fb, gp, gi, gd));
    endtask

    task automatic wait_done(output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0; start = 1'b0; clear = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, done} !== 2'b00 || u_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b u_out=%0d, want 0 0 0", busy, done, u_out);
        end
        rst_n = 1'b1;
        model_reset();
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) n++;
        end
        vectors++;
        if (n != 0) begin
            miscompares++;
            $display("FAIL reset_no_done: got %0d done pulses, want 0", n);
        end
    endtask

    task automatic run_one(input string name, input int sp, input int fb, input int gp, input int gi, input int gd);
        int lat, expv, held;
        bit got;
        apply(sp, fb, gp, gi, gd);
        wait_done(lat, got);
        expv = exp_q.pop_front();
        vectors++;
        if (!got || lat != 5) begin
            miscompares++;
            $display("FAIL %s_latency: got=%0b lat=%0d, want done at 5", name, got, lat);
        end
        vectors++;
        if (u_val() !== expv) begin
            miscompares++;
            $display("FAIL %s_value: u_out=%0d, want %0d", name, u_val(), expv);
        end
        held = u_val();
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || u_val() !== held) begin
            miscompares++;
            $display("FAIL %s_pulse: done=%b u_out=%0d, want 0 and %0d", name, done, u_val(), held);
        end
    endtask

    task automatic test_basic();
        run_one("first", 100, 40, 2, 1, 3);
        run_one("repeat", 100, 40, 2, 1, 3);
        clear = 1'b1; start = 1'b1;
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        m_integ = 0; m_eprev = 0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_priority: busy=%b, want 0", busy);
        end
        run_one("after_clear", 100, 40, 2, 1, 3);
    endtask

    task automatic test_saturation();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_one("saturate", 30000, -30000, 1, 0, 1);
    endtask

    task automatic test_wrap();
        run_one("wrap", 300, 0, 300, 0, 0);
        run_one("negative", 0, 5, 4, 0, 0);
    endtask

    task automatic test_ignore_busy();
        int n, pos, expv;
        apply(10, 3, 5, 2, 1);
        n = 0; pos = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = (i == 1 || i == 3);
            clear = (i == 2);
            if (i == 1) setpoint = 16'd9999;
            if (done) begin
                n++;
                if (pos == 0) pos = i;
                expv = exp_q.pop_front();
                vectors++;
                if (u_val() !== expv) begin
                    miscompares++;
                    $display("FAIL ignore_value: u_out=%0d, want %0d", u_val(), expv);
                end
            end
            if (i == 4) begin start = 1'b0; clear = 1'b0; end
        end
        vectors++;
        if (n != 1 || pos != 5) begin
            miscompares++;
            $display("FAIL ignore_busy: dones=%0d first_at=%0d, want 1 at 5", n, pos);
        end
    endtask

    task automatic test_back_to_back();
        int n, expv;
        drive(50, 20, 3, 2, 1);
        for (int j = 0; j < 4; j++) exp_q.push_back(model_update(50, 20, 3, 2, 1));
        start = 1'b1;
        n = 0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (i == 20) start = 1'b0;
            if (done) begin
                n++;
                vectors++;
                if (i != 5 * n || exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_spacing: done %0d at cycle %0d, want %0d", n, i, 5 * n);
                end else begin
                    expv = exp_q.pop_front();
                    vectors++;
                    if (u_val() !== expv) begin
                        miscompares++;
                        $display("FAIL b2b_value: u_out=%0d, want %0d", u_val(), expv);
                    end
                end
            end
        end
        vectors++;
        if (n != 4) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d dones, want 4", n);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        apply(100, 40, 2, 1, 3);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        vectors++;
        if ({busy, done} !== 2'b00 || u_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_mid_state: busy=%b done=%b u_out=%0d, want 0 0 0", busy, done, u_out);
        end
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) n++;
        end
        vectors++;
        if (n != 0) begin
            miscompares++;
            $display("FAIL reset_mid_done: got %0d dones, want 0", n);
        end
        run_one("post_reset", 100, 40, 2, 1, 3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_wrap();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
